// File: rtl/vx_dispatch_arb_pkg.sv
// vx_dispatch_arb_pkg: configuration, FSM state type and the packet-slice
// search helper shared by the dispatch arbiter files.
package vx_dispatch_arb_pkg;

  localparam int NUM_REQS      = 4;
  localparam int NUM_THREADS   = 4;
  localparam int NUM_LANES     = 2;
  localparam int HDR_W         = 64;
  localparam int LANE_W        = 96;
  localparam int NUM_PKTS      = NUM_THREADS / NUM_LANES;
  localparam int PID_W         = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
  localparam int ISW_W         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int PERF_CTR_BITS = 32;

  typedef enum logic [0:0] {
    DARB_IDLE = 1'b0,
    DARB_BUSY = 1'b1
  } dispatch_arb_state_t;

  typedef struct packed {
    logic             found;
    logic [PID_W-1:0] idx;
  } slice_pick_t;

  // Lowest packet slice at or above 'from' whose lane mask is nonzero.
  // 'from' is one bit wider than a pid so "past the last slice" is expressible.
  function automatic slice_pick_t next_nonzero_slice(
    input logic [NUM_THREADS-1:0] tmask,
    input logic [PID_W:0]         from
  );
    slice_pick_t res;
    res.found = 1'b0;
    res.idx   = '0;
    for (int p = NUM_PKTS - 1; p >= 0; p--) begin
      if ((p >= int'(from)) && (|tmask[p*NUM_LANES +: NUM_LANES])) begin
        res.found = 1'b1;
        res.idx   = PID_W'(p);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vx_dispatch_arb_chk.sv
// vx_dispatch_arb_chk: simulation checks on the arbiter's input contract.
module vx_dispatch_arb_chk
  import vx_dispatch_arb_pkg::*;
(
  input logic                clk,
  input logic                reset_n,
  input logic [NUM_REQS-1:0] in_valid,
  input logic                out_valid,
  input logic [ISW_W-1:0]    out_isw
);

  // A locked requester must keep its request raised until it is released.
  hold_valid_while_busy: assert property (
    @(posedge clk) disable iff (!reset_n) out_valid |-> in_valid[out_isw]
  );

endmodule

// File: rtl/vx_rr_pick.sv
// vx_rr_pick: combinational round-robin pick of the first set request bit
// at or after a pointer, wrapping modulo N.
module vx_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [PW-1:0] w_cand [N];

  for (genvar g = 0; g < N; g++) begin : g_cand
    assign w_cand[g] = PW'((int'(i_ptr) + g) % N);
  end

  // Scan offsets from farthest to nearest so the nearest hit to the pointer wins.
  always_comb begin
    o_idx = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (i_req[w_cand[off]]) begin
        o_idx = w_cand[off];
      end else begin
        o_idx = o_idx;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/vx_dispatch_arb.sv
// vx_dispatch_arb: round-robin lock-and-stream scheduler that feeds one
// execution unit with NUM_LANES-wide packets, skipping empty packets.
// Optional perf counters are enabled with `define VX_DISPATCH_ARB_PERF_EN.
module vx_dispatch_arb
  import vx_dispatch_arb_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQS-1:0]                 in_valid,
  output logic [NUM_REQS-1:0]                 in_ready,
  input  logic [NUM_REQS*NUM_THREADS-1:0]     in_tmask,
  input  logic [NUM_REQS*HDR_W-1:0]           in_hdr,
  input  logic [NUM_REQS*NUM_THREADS*LANE_W-1:0] in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_LANES-1:0]                out_tmask,
  output logic [HDR_W-1:0]                    out_hdr,
  output logic [NUM_LANES*LANE_W-1:0]         out_data,
  output logic [PID_W-1:0]                    out_pid,
  output logic                                out_sop,
  output logic                                out_eop,
  output logic [ISW_W-1:0]                    out_isw
`ifdef VX_DISPATCH_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]            perf_stalls,
  output logic [NUM_REQS*PERF_CTR_BITS-1:0]   perf_grants
`endif
);

  dispatch_arb_state_t r_state, w_state_nxt;
  logic [ISW_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [ISW_W-1:0]    r_grant, w_grant_nxt;
  logic [PID_W-1:0]    r_pid, w_pid_nxt;
  logic                r_first, w_first_nxt;

  logic [NUM_THREADS-1:0]      w_req_tmask [NUM_REQS];
  logic [HDR_W-1:0]            w_req_hdr   [NUM_REQS];
  logic [NUM_LANES-1:0]        w_req_lmask [NUM_REQS][NUM_PKTS];
  logic [NUM_LANES*LANE_W-1:0] w_req_pkt   [NUM_REQS][NUM_PKTS];

  logic [ISW_W-1:0] w_pick_idx;
  logic             w_pick_any;
  slice_pick_t      w_pick_first;
  slice_pick_t      w_cur_next;
  logic             w_fire;
  logic             w_eop;

  // Unpack the flat request buses into per-request / per-packet views.
  for (genvar g = 0; g < NUM_REQS; g++) begin : g_req
    assign w_req_tmask[g] = in_tmask[g*NUM_THREADS +: NUM_THREADS];
    assign w_req_hdr[g]   = in_hdr[g*HDR_W +: HDR_W];
    for (genvar p = 0; p < NUM_PKTS; p++) begin : g_pkt
      assign w_req_lmask[g][p] = in_tmask[g*NUM_THREADS + p*NUM_LANES +: NUM_LANES];
      assign w_req_pkt[g][p]   = in_data[(g*NUM_THREADS + p*NUM_LANES)*LANE_W +: NUM_LANES*LANE_W];
    end
  end

  vx_rr_pick #(
    .N  (NUM_REQS),
    .PW (ISW_W)
  ) u_rr_pick (
    .i_req (in_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  vx_dispatch_arb_chk u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .out_isw   (out_isw)
  );

  // First packet of the request about to be granted, and the packet after the current one.
  assign w_pick_first = next_nonzero_slice(w_req_tmask[w_pick_idx], '0);
  assign w_cur_next   = next_nonzero_slice(w_req_tmask[r_grant],
                                           {1'b0, r_pid} + {{PID_W{1'b0}}, 1'b1});

  assign out_valid = (r_state == DARB_BUSY);
  assign w_fire    = out_valid && out_ready;
  assign w_eop     = !w_cur_next.found;

  assign out_tmask = w_req_lmask[r_grant][r_pid];
  assign out_data  = w_req_pkt[r_grant][r_pid];
  assign out_hdr   = w_req_hdr[r_grant];
  assign out_pid   = r_pid;
  assign out_sop   = r_first;
  assign out_eop   = w_eop;
  assign out_isw   = r_grant;

  // Release the locked requester in the same cycle its last packet is taken.
  always_comb begin
    in_ready = '0;
    if (w_fire && w_eop) begin
      in_ready[r_grant] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Next-state logic: lock onto a winner in IDLE, walk its nonzero packets in BUSY.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_grant_nxt  = r_grant;
    w_pid_nxt    = r_pid;
    w_first_nxt  = r_first;
    case (r_state)
      DARB_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = DARB_BUSY;
          w_grant_nxt = w_pick_idx;
          w_pid_nxt   = w_pick_first.found ? w_pick_first.idx : '0;
          w_first_nxt = 1'b1;
        end else begin
          w_state_nxt = DARB_IDLE;
        end
      end
      DARB_BUSY: begin
        if (w_fire && w_eop) begin
          w_state_nxt  = DARB_IDLE;
          w_rr_ptr_nxt = ISW_W'((int'(r_grant) + 1) % NUM_REQS);
        end else if (w_fire) begin
          w_pid_nxt   = w_cur_next.idx;
          w_first_nxt = 1'b0;
        end else begin
          w_state_nxt = DARB_BUSY;
        end
      end
      default: begin
        w_state_nxt = DARB_IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight request without releasing it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= DARB_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_pid    <= '0;
      r_first  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_grant  <= w_grant_nxt;
      r_pid    <= w_pid_nxt;
      r_first  <= w_first_nxt;
    end
  end

`ifdef VX_DISPATCH_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] r_perf_stalls;
  logic [PERF_CTR_BITS-1:0] r_perf_grants [NUM_REQS];

  // Count cycles where a packet is offered but the unit refuses it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stalls <= '0;
    end else if (out_valid && !out_ready) begin
      r_perf_stalls <= r_perf_stalls + PERF_CTR_BITS'(1);
    end
  end

  assign perf_stalls = r_perf_stalls;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_perf
    // Count IDLE->BUSY transitions that lock onto this issue slice.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_perf_grants[g] <= '0;
      end else if ((r_state == DARB_IDLE) && w_pick_any && (w_pick_idx == ISW_W'(g))) begin
        r_perf_grants[g] <= r_perf_grants[g] + PERF_CTR_BITS'(1);
      end
    end
    assign perf_grants[g*PERF_CTR_BITS +: PERF_CTR_BITS] = r_perf_grants[g];
  end
`else
  // Counters are not built; scheduling behaviour is unaffected.
`endif

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// tb_vx_dispatch_arb: table-driven, hand-sequenced and randomized checks of
// vx_dispatch_arb against a request-level model of the packet stream.
module tb_vx_dispatch_arb;
  import vx_dispatch_arb_pkg::*;

  logic clk;
  logic reset_n;
  logic [NUM_REQS-1:0]                    in_valid;
  logic [NUM_REQS-1:0]                    in_ready;
  logic [NUM_REQS*NUM_THREADS-1:0]        in_tmask;
  logic [NUM_REQS*HDR_W-1:0]              in_hdr;
  logic [NUM_REQS*NUM_THREADS*LANE_W-1:0] in_data;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [NUM_LANES-1:0]                   out_tmask;
  logic [HDR_W-1:0]                       out_hdr;
  logic [NUM_LANES*LANE_W-1:0]            out_data;
  logic [PID_W-1:0]                       out_pid;
  logic                                   out_sop;
  logic                                   out_eop;
  logic [ISW_W-1:0]                       out_isw;
`ifdef VX_DISPATCH_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0]               perf_stalls;
  logic [NUM_REQS*PERF_CTR_BITS-1:0]      perf_grants;
`endif

  vx_dispatch_arb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tmask  (in_tmask),
    .in_hdr    (in_hdr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tmask (out_tmask),
    .out_hdr   (out_hdr),
    .out_data  (out_data),
    .out_pid   (out_pid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_isw   (out_isw)
`ifdef VX_DISPATCH_ARB_PERF_EN
    ,
    .perf_stalls (perf_stalls),
    .perf_grants (perf_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request-level model state
  logic [NUM_THREADS-1:0]        m_tmask [NUM_REQS];
  logic [HDR_W-1:0]              m_hdr   [NUM_REQS];
  logic [NUM_THREADS*LANE_W-1:0] m_data  [NUM_REQS];
  logic [NUM_REQS-1:0]           m_valid;
  int                            m_ptr;
  int                            m_stalls;
  int                            m_grants [NUM_REQS];

  int n_tests;
  int n_fail;

  typedef struct {
    logic [NUM_THREADS-1:0] tmask;
    int                     n_pkts;
    int                     first_pid;
    int                     slice;
  } vec_t;

  vec_t vecs [6];
  int   rr_exp [5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NUM_REQS; r++) begin
      in_tmask[r*NUM_THREADS +: NUM_THREADS]              = m_tmask[r];
      in_hdr[r*HDR_W +: HDR_W]                            = m_hdr[r];
      in_data[r*NUM_THREADS*LANE_W +: NUM_THREADS*LANE_W] = m_data[r];
    end
    in_valid = m_valid;
  endtask

  task automatic set_req(input int r, input logic [NUM_THREADS-1:0] tm);
    m_tmask[r] = tm;
    m_hdr[r]   = {$urandom, $urandom};
    for (int w = 0; w < (NUM_THREADS*LANE_W)/32; w++) begin
      m_data[r][w*32 +: 32] = $urandom;
    end
    m_valid[r] = 1'b1;
  endtask

  // First valid requester at or after the fairness pointer, wrapping around.
  function automatic int model_pick();
    int sel;
    sel = -1;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (m_valid[(m_ptr + i) % NUM_REQS]) sel = (m_ptr + i) % NUM_REQS;
    end
    return sel;
  endfunction

  // Called at the negedge after the grant edge; walks every expected packet.
  task automatic run_transfer(input int slice, input int stall_pkt, input int stall_len,
                              input int rnd_max, output int obs_n, output int obs_first,
                              output int obs_isw);
    int pids[$];
    int stalls;
    int last;
    logic [NUM_REQS-1:0] exp_rdy;
    for (int p = 0; p < NUM_PKTS; p++) begin
      if (m_tmask[slice][p*NUM_LANES +: NUM_LANES] != '0) pids.push_back(p);
    end
    if (pids.size() == 0) pids.push_back(0);
    last      = pids.size() - 1;
    obs_n     = 0;
    obs_first = -1;
    obs_isw   = -1;
    for (int k = 0; k <= last; k++) begin
      stalls = (k == stall_pkt) ? stall_len : ((rnd_max > 0) ? $urandom_range(rnd_max, 0) : 0);
      for (int s = 0; s <= stalls; s++) begin
        out_ready = (s == stalls);
        #1;
        if (k == 0 && s == 0) begin
          obs_first = int'(out_pid);
          obs_isw   = int'(out_isw);
        end
        chk("out_valid", out_valid, 1'b1);
        chk("out_isw", out_isw, slice);
        chk("out_pid", out_pid, pids[k]);
        chk("out_sop", out_sop, k == 0);
        chk("out_eop", out_eop, k == last);
        chk("out_tmask", out_tmask, m_tmask[slice][pids[k]*NUM_LANES +: NUM_LANES]);
        chk("out_hdr", out_hdr, m_hdr[slice]);
        chk("out_data", out_data, m_data[slice][pids[k]*NUM_LANES*LANE_W +: NUM_LANES*LANE_W]);
        exp_rdy = '0;
        if (s == stalls && k == last) exp_rdy[slice] = 1'b1;
        chk("in_ready", in_ready, exp_rdy);
        if (out_eop === 1'b1 && s == stalls && obs_n == 0) obs_n = k + 1;
        if (s != stalls) m_stalls++;
        @(negedge clk);
      end
    end
    out_ready = 1'b0;
  endtask

  // Called at a negedge with the DUT idle and requests already driven.
  task automatic grant_and_serve(input int stall_pkt, input int stall_len, input int rnd_max,
                                 output int obs_n, output int obs_first, output int obs_isw);
    int sel;
    sel = model_pick();
    #1;
    chk("idle_out_valid", out_valid, 1'b0);
    if (sel < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL no_request: bench reached a grant with no valid requester");
      obs_n = 0;
      obs_first = -1;
      obs_isw = -1;
    end else begin
      m_grants[sel]++;
      @(negedge clk);
      run_transfer(sel, stall_pkt, stall_len, rnd_max, obs_n, obs_first, obs_isw);
      m_ptr = (sel + 1) % NUM_REQS;
      m_valid[sel] = 1'b0;
      drive();
    end
  endtask

  task automatic drain();
    int n, fp, isw;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (m_valid != '0) grant_and_serve(-1, 0, 1, n, fp, isw);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fp, isw;
    logic [NUM_THREADS-1:0] tm;

    vecs[0] = '{4'b1111, 2, 0, 0};
    vecs[1] = '{4'b1100, 1, 1, 1};
    vecs[2] = '{4'b0000, 1, 0, 2};
    vecs[3] = '{4'b0011, 1, 0, 3};
    vecs[4] = '{4'b0110, 2, 0, 0};
    vecs[5] = '{4'b1001, 2, 0, 2};
    rr_exp  = '{0, 1, 2, 3, 0};

    n_tests  = 0;
    n_fail   = 0;
    m_ptr    = 0;
    m_stalls = 0;
    m_valid  = '0;
    for (int r = 0; r < NUM_REQS; r++) begin
      m_tmask[r]  = '0;
      m_hdr[r]    = '0;
      m_data[r]   = '0;
      m_grants[r] = 0;
    end
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin: all four slices held valid
    for (int r = 0; r < NUM_REQS; r++) set_req(r, 4'b0011);
    drive();
    for (int g = 0; g < 5; g++) begin
      grant_and_serve(-1, 0, 0, n, fp, isw);
      chk("rr_order", isw, rr_exp[g]);
      for (int r = 0; r < NUM_REQS; r++) begin
        if (!m_valid[r]) set_req(r, 4'b0011);
      end
      drive();
    end
    drain();

    // Table of single requests: packet count, first pid, source slice
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].slice, vecs[v].tmask);
      drive();
      grant_and_serve(-1, 0, 0, n, fp, isw);
      chk("vec_npkts", n, vecs[v].n_pkts);
      chk("vec_first_pid", fp, vecs[v].first_pid);
      chk("vec_isw", isw, vecs[v].slice);
    end

    // Backpressure: five refused cycles on the second packet
    set_req(0, 4'b1111);
    drive();
    grant_and_serve(1, 5, 0, n, fp, isw);
    chk("bp_npkts", n, 2);

    // Async reset while streaming the second packet
    set_req(1, 4'b1111);
    drive();
    grant_and_serve(-1, 0, 0, n, fp, isw);
    set_req(0, 4'b1111);
    drive();
    #1;
    chk("arst_pre_idle", out_valid, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("arst_pre_pid0", out_pid, 0);
    @(negedge clk);
    set_req(2, 4'b0101);
    drive();
    out_ready = 1'b0;
    #1;
    chk("arst_pre_valid", out_valid, 1'b1);
    chk("arst_pre_pid1", out_pid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, '0);
    m_ptr    = 0;
    m_stalls = 0;
    for (int r = 0; r < NUM_REQS; r++) m_grants[r] = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    grant_and_serve(-1, 0, 0, n, fp, isw);
    chk("arst_regrant_isw", isw, 0);
    chk("arst_regrant_pid", fp, 0);
    grant_and_serve(-1, 0, 0, n, fp, isw);
    chk("arst_next_isw", isw, 2);

    // Randomized traffic with random backpressure
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < NUM_REQS; r++) begin
        if (!m_valid[r] && ($urandom_range(1, 0) == 1)) begin
          tm = NUM_THREADS'($urandom);
          set_req(r, tm);
        end
      end
      if (m_valid == '0) begin
        tm = NUM_THREADS'($urandom);
        set_req($urandom_range(NUM_REQS - 1, 0), tm);
      end
      drive();
      grant_and_serve(-1, 0, 2, n, fp, isw);
    end
    drain();

`ifdef VX_DISPATCH_ARB_PERF_EN
    #1;
    chk("perf_stalls", perf_stalls, m_stalls);
    for (int r = 0; r < NUM_REQS; r++) begin
      chk("perf_grants", perf_grants[r*PERF_CTR_BITS +: PERF_CTR_BITS], m_grants[r]);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
